fitness_report_tx: RTL and testbench
====================================

Name: fitness_report_tx

Overview:
- Serial transmit end for the fitness tracker's results.
- On a `send` request it snapshots the tracker outputs: per-activity seconds, per-activity calories, speed and THR.
- It serialises the snapshot as a fixed 16-byte frame over a UART-style 8N1 line to the display/host link.
- It sits beside `fitness_tracker` at the top level and consumes its outputs unchanged.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..65535.
- HEADER, 8'hA5, frame sync byte sent first.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets).
- send  input  1  request to transmit one frame; level sampled each clk.
- seconds_Run  input  8  run time.
- seconds_Walk  input  8  walk time.
- seconds_Cycle  input  8  cycle time.
- calories_Run  input  24  run calories.
- calories_Walk  input  24  walk calories.
- calories_Cycle  input  24  cycle calories.
- speed  input  8  speed.
- THR  input  8  target heart rate.
- tx  output  1  serial line; idle high.
- busy  output  1  high while a frame is in flight.
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (rst=0, asynchronous): tx=1, busy=0, done=0, state=IDLE, all counters and the snapshot cleared.
  - Reset mid-frame aborts the frame immediately; tx returns high without completing the byte.
  - No done pulse is issued for an aborted frame.
- All outputs are registered.
- Frame byte order, index 0..15, each byte LSB first:
  - 0: HEADER.
  - 1–3: seconds_Run, seconds_Walk, seconds_Cycle.
  - 4–6: calories_Run[23:16], [15:8], [7:0].
  - 7–9: calories_Walk, same order.
  - 10–12: calories_Cycle, same order.
  - 13: speed.
  - 14: THR.
  - 15: checksum = XOR of bytes 1..14 (header excluded).
- Snapshot: all inputs and the checksum are latched on the edge where send=1 and state=IDLE. Later input changes do not affect the frame in flight.
- Byte format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit is held exactly CLKS_PER_BIT cycles. No idle gap between bytes.
- State machine:
  - IDLE: tx=1. If send=1, latch snapshot, set byte_idx=0, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx=current byte[bit_idx]. After CLKS_PER_BIT cycles, bit_idx++. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if byte_idx=15, go to IDLE; else byte_idx++ and go to START.
- Latency and timing:
  - send sampled at edge N in IDLE → busy=1 and tx=0 visible after edge N.
  - The frame occupies exactly 160*CLKS_PER_BIT cycles.
  - On the edge ending the final stop bit, busy falls and done=1 for exactly one cycle.
- Handshake:
  - send while busy=1 is ignored; no queuing.
  - send held high continuously produces back-to-back frames, each starting in the cycle after done. This is one IDLE cycle per frame.
- Counters:
  - baud_cnt runs 0..CLKS_PER_BIT-1 and wraps at the bit boundary.
  - bit_idx is 3 bits; byte_idx is 4 bits.
  - No counter may overflow outside these ranges.

Test Plan:
- Reset idle: rst=0 for 3 cycles, then 1, send=0 → tx=1, busy=0, done=0 held for 200 cycles.
- Single frame, CLKS_PER_BIT=16, with seconds_Run=0x0A, calories_Run=0x000C1C, speed=0x03, THR=0x4B, all other inputs 0:
  - Decoded bytes are A5 0A 00 00 00 0C 1C 00 00 00 00 00 00 03 4B 52.
  - busy is high for exactly 2560 cycles; done pulses once.
- Snapshot/ignore: change every input and pulse send mid-frame → transmitted bytes match the values at the original send edge; no second frame follows.
- Bit timing: measure tx edges for a frame of all 0x55 payload bytes → every bit width is exactly 16 cycles; stop bits are high; checksum byte is 0x00.
- Back-to-back: hold send=1 for two frames → second start bit begins one cycle after done; done pulses twice, 2561 cycles apart.
- Reset mid-frame: assert rst=0 during byte 7 → tx=1 and busy=0 within the same cycle (asynchronous); no done pulse; the next send transmits a full fresh frame from the header.

Source files
------------

// File: rtl/fitness_report_tx.sv
// Serial 8N1 transmitter for fitness tracker results: snapshots the tracker
// outputs on send and shifts them out as a fixed 16-byte frame with an XOR checksum.
module fitness_report_tx #(
    parameter int         CLKS_PER_BIT = 16,
    parameter logic [7:0] HEADER       = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send,
    input  logic [7:0]  seconds_Run,
    input  logic [7:0]  seconds_Walk,
    input  logic [7:0]  seconds_Cycle,
    input  logic [23:0] calories_Run,
    input  logic [23:0] calories_Walk,
    input  logic [23:0] calories_Cycle,
    input  logic [7:0]  speed,
    input  logic [7:0]  THR,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    function automatic logic [7:0] xor_checksum(input logic [13:0][7:0] payload);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 14; i++) begin
            acc = acc ^ payload[i];
        end
        return acc;
    endfunction

    state_t           state_r;
    logic [15:0]      baud_cnt_r;
    logic [2:0]       bit_idx_r;
    logic [3:0]       byte_idx_r;
    logic [15:0][7:0] frame_r;
    logic             tx_r;
    logic             busy_r;
    logic             done_r;

    logic [13:0][7:0] payload_s;
    logic [15:0][7:0] frame_s;
    logic             bit_end_s;
    logic [7:0]       cur_byte_s;
    logic [2:0]       next_bit_s;

    // Assemble the candidate frame from the live inputs; it is only latched in IDLE.
    always_comb begin
        payload_s[0]  = seconds_Run;
        payload_s[1]  = seconds_Walk;
        payload_s[2]  = seconds_Cycle;
        payload_s[3]  = calories_Run[23:16];
        payload_s[4]  = calories_Run[15:8];
        payload_s[5]  = calories_Run[7:0];
        payload_s[6]  = calories_Walk[23:16];
        payload_s[7]  = calories_Walk[15:8];
        payload_s[8]  = calories_Walk[7:0];
        payload_s[9]  = calories_Cycle[23:16];
        payload_s[10] = calories_Cycle[15:8];
        payload_s[11] = calories_Cycle[7:0];
        payload_s[12] = speed;
        payload_s[13] = THR;
        frame_s[0]    = HEADER;
        frame_s[14:1] = payload_s;
        frame_s[15]   = xor_checksum(payload_s);
        bit_end_s     = (baud_cnt_r == LAST_CNT);
        cur_byte_s    = frame_r[byte_idx_r];
        next_bit_s    = bit_idx_r + 3'd1;
    end

    // Frame sequencer; tx is loaded with the value of the bit that starts on this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            baud_cnt_r <= 16'd0;
            bit_idx_r  <= 3'd0;
            byte_idx_r <= 4'd0;
            frame_r    <= '0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    baud_cnt_r <= 16'd0;
                    bit_idx_r  <= 3'd0;
                    byte_idx_r <= 4'd0;
                    if (send) begin
                        frame_r <= frame_s;
                        tx_r    <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= START;
                    end else begin
                        tx_r    <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= 16'd0;
                        bit_idx_r  <= 3'd0;
                        tx_r       <= cur_byte_s[0];
                        state_r    <= DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= 16'd0;
                        if (bit_idx_r == 3'd7) begin
                            tx_r    <= 1'b1;
                            state_r <= STOP;
                        end else begin
                            bit_idx_r <= next_bit_s;
                            tx_r      <= cur_byte_s[next_bit_s];
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= 16'd0;
                        if (byte_idx_r == 4'd15) begin
                            tx_r    <= 1'b1;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= IDLE;
                        end else begin
                            byte_idx_r <= byte_idx_r + 4'd1;
                            tx_r       <= 1'b0;
                            state_r    <= START;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    baud_cnt_r <= 16'd0;
                    bit_idx_r  <= 3'd0;
                    byte_idx_r <= 4'd0;
                    tx_r       <= 1'b1;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign tx   = tx_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_fitness_report_tx.sv
// Directed bench for fitness_report_tx: decodes the serial line and compares
// against hand-computed frames, timing and handshake expectations.
module tb_fitness_report_tx;

    typedef logic [7:0] frame_t [16];

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        send = 1'b0;
    logic [7:0]  seconds_Run = 8'h00, seconds_Walk = 8'h00, seconds_Cycle = 8'h00;
    logic [23:0] calories_Run = 24'h0, calories_Walk = 24'h0, calories_Cycle = 24'h0;
    logic [7:0]  speed = 8'h00, THR = 8'h00;
    logic        tx, busy, done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int busy_cycles = 0;
    int done_count  = 0;
    int done_cyc[$];
    int edge_cyc[$];
    logic prev_tx = 1'b1;
    bit   log_en  = 1'b0;

    fitness_report_tx #(.CLKS_PER_BIT(16), .HEADER(8'hA5)) dut (
        .clk(clk), .rst(rst), .send(send),
        .seconds_Run(seconds_Run), .seconds_Walk(seconds_Walk), .seconds_Cycle(seconds_Cycle),
        .calories_Run(calories_Run), .calories_Walk(calories_Walk), .calories_Cycle(calories_Cycle),
        .speed(speed), .THR(THR), .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: busy duration, done pulses and tx transition times.
    always @(negedge clk) begin
        if (busy === 1'b1) busy_cycles++;
        if (done === 1'b1) begin
            done_count++;
            done_cyc.push_back(cyc);
        end
        if (log_en && tx !== prev_tx) edge_cyc.push_back(cyc);
        prev_tx = tx;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_inputs(input logic [7:0] sr, input logic [7:0] sw, input logic [7:0] sc,
                              input logic [23:0] cr, input logic [23:0] cw, input logic [23:0] cc,
                              input logic [7:0] sp, input logic [7:0] th);
        seconds_Run = sr; seconds_Walk = sw; seconds_Cycle = sc;
        calories_Run = cr; calories_Walk = cw; calories_Cycle = cc;
        speed = sp; THR = th;
    endtask

    task automatic pulse_send(output int start);
        @(posedge clk);
        #1 send = 1'b1;
        @(posedge clk);
        #1 start = cyc;
        send = 1'b0;
    endtask

    task automatic recv_byte(output logic [7:0] b, output logic stop_bit, output bit timed_out);
        int t;
        t = 0; b = 8'h00; stop_bit = 1'b0; timed_out = 1'b0;
        @(negedge clk);
        while (tx !== 1'b0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (tx !== 1'b0) begin
            timed_out = 1'b1;
            return;
        end
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (16) @(negedge clk);
            b[i] = tx;
        end
        repeat (16) @(negedge clk);
        stop_bit = tx;
    endtask

    task automatic recv_frame(input frame_t exp, input string tag);
        logic [7:0] b;
        logic       sb;
        bit         to;
        for (int k = 0; k < 16; k++) begin
            recv_byte(b, sb, to);
            if (to) begin
                check($sformatf("%s timeout byte%0d", tag, k), 32'd1, 32'd0);
                return;
            end
            check($sformatf("%s byte%0d", tag, k), {24'h0, b}, {24'h0, exp[k]});
            check($sformatf("%s stop%0d", tag, k), {31'h0, sb}, 32'd1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        frame_t exp1, exp2, exp3;
        int start, bd, bb, ei, bad, t;
        logic [7:0] b;
        logic sb;
        bit to;
        int exp_edges[$];
        logic bit_v, prev_v;

        exp1 = '{8'hA5, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h1C, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 8'h4B, 8'h52};
        exp2 = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h12, 8'h34, 8'h56, 8'h00,
                 8'h01, 8'h00, 8'hAB, 8'hCD, 8'hEF, 8'h07, 8'h80, 8'h7F};
        exp3 = '{8'hA5, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55,
                 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h00};

        // Reset and idle hold
        repeat (3) @(posedge clk);
        #1;
        check("reset tx", {31'h0, tx}, 32'd1);
        check("reset busy", {31'h0, busy}, 32'd0);
        check("reset done", {31'h0, done}, 32'd0);
        rst = 1'b1;
        bd = done_count; bb = busy_cycles; bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        check("idle hold", bad, 32'd0);
        check("idle busy cycles", busy_cycles - bb, 32'd0);

        // Single frame
        set_inputs(8'h0A, 8'h00, 8'h00, 24'h000C1C, 24'h0, 24'h0, 8'h03, 8'h4B);
        bd = done_count; bb = busy_cycles;
        pulse_send(start);
        recv_frame(exp1, "single");
        repeat (50) @(negedge clk);
        check("single busy cycles", busy_cycles - bb, 32'd2560);
        check("single done count", done_count - bd, 32'd1);
        if (done_count > bd) check("single done time", done_cyc[bd] - start, 32'd2560);
        check("single idle tx", {31'h0, tx}, 32'd1);

        // Snapshot holds while inputs change; mid-frame send ignored
        set_inputs(8'h11, 8'h22, 8'h33, 24'h123456, 24'h000100, 24'hABCDEF, 8'h07, 8'h80);
        bd = done_count;
        pulse_send(start);
        fork
            recv_frame(exp2, "snap");
            begin
                repeat (600) @(posedge clk);
                #1 set_inputs(8'hFF, 8'hEE, 8'hDD, 24'hCCCCCC, 24'hBBBBBB, 24'hAAAAAA, 8'h99, 8'h88);
                send = 1'b1;
                @(posedge clk);
                #1 send = 1'b0;
            end
        join
        repeat (3000) @(negedge clk);
        check("snap done count", done_count - bd, 32'd1);
        check("snap no refire busy", {31'h0, busy}, 32'd0);

        // Bit timing with 0x55 payload
        set_inputs(8'h55, 8'h55, 8'h55, 24'h555555, 24'h555555, 24'h555555, 8'h55, 8'h55);
        ei = edge_cyc.size();
        log_en = 1'b1;
        pulse_send(start);
        recv_frame(exp3, "pattern");
        repeat (20) @(negedge clk);
        log_en = 1'b0;
        prev_v = 1'b1;
        for (int k = 0; k < 160; k++) begin
            case (k % 10)
                0: bit_v = 1'b0;
                9: bit_v = 1'b1;
                default: begin
                    b = exp3[k / 10];
                    bit_v = b[(k % 10) - 1];
                end
            endcase
            if (bit_v != prev_v) exp_edges.push_back(k * 16);
            prev_v = bit_v;
        end
        check("pattern edge count", edge_cyc.size() - ei, exp_edges.size());
        for (int j = 0; j < exp_edges.size(); j++) begin
            if (ei + j < edge_cyc.size())
                check($sformatf("pattern edge%0d", j), edge_cyc[ei + j] - start, exp_edges[j]);
        end

        // Back-to-back frames with send held high
        set_inputs(8'h0A, 8'h00, 8'h00, 24'h000C1C, 24'h0, 24'h0, 8'h03, 8'h4B);
        bd = done_count;
        @(posedge clk);
        #1 send = 1'b1;
        @(posedge clk);
        #1 start = cyc;
        fork
            begin
                recv_frame(exp1, "b2b first");
                recv_frame(exp1, "b2b second");
            end
            begin
                t = 0;
                while (done !== 1'b1 && t < 4000) begin
                    @(negedge clk);
                    t++;
                end
                check("b2b done seen", {31'h0, done}, 32'd1);
                @(negedge clk);
                check("b2b restart tx", {31'h0, tx}, 32'd0);
                check("b2b restart busy", {31'h0, busy}, 32'd1);
                send = 1'b0;
            end
        join
        repeat (3000) @(negedge clk);
        check("b2b done count", done_count - bd, 32'd2);
        if (done_count >= bd + 2) begin
            check("b2b first done", done_cyc[bd] - start, 32'd2560);
            check("b2b done gap", done_cyc[bd + 1] - done_cyc[bd], 32'd2561);
        end

        // Reset in the middle of byte 7
        bd = done_count;
        pulse_send(start);
        for (int k = 0; k < 7; k++) begin
            recv_byte(b, sb, to);
            if (k == 0) check("abort header", {24'h0, b}, 32'hA5);
        end
        repeat (40) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort tx", {31'h0, tx}, 32'd1);
        check("abort busy", {31'h0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3000) @(negedge clk);
        check("abort no done", done_count - bd, 32'd0);
        check("abort idle tx", {31'h0, tx}, 32'd1);
        bd = done_count;
        pulse_send(start);
        recv_frame(exp1, "after reset");
        repeat (50) @(negedge clk);
        check("after reset done", done_count - bd, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
